ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Arbitrates one block-RAM read port between a display client and a host, plus a write
// port shared between host writes and a full-memory clear sweep.
module ram_arbiter #(
  parameter int            W         = 8,
  parameter int            L         = 32,
  parameter logic [W-1:0]  CLEAR_VAL = '0,
  localparam int           AW        = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [W-1:0]  disp_data,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic          host_ready,
  output logic          resp_valid,
  output logic [W-1:0]  resp_data,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [W-1:0]  ram_rd_data,
  output logic          ram_wr_ena,
  output logic [AW-1:0] ram_wr_addr,
  output logic [W-1:0]  ram_wr_data
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(L - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          cmd_ok, host_rd_grant, host_wr_grant;

  // Host commands only land in IDLE, and a same-cycle clear_start takes precedence.
  assign cmd_ok        = host_valid && !rst && (state == IDLE) && !clear_start;
  assign host_wr_grant = cmd_ok && host_we;
  assign host_rd_grant = cmd_ok && !host_we && !disp_req;
  assign host_ready    = host_wr_grant || host_rd_grant;

  assign ram_rd_addr = disp_req ? disp_addr : host_addr;
  assign disp_data   = ram_rd_data;
  assign resp_data   = ram_rd_data;

  // Writes are suppressed during reset so an aborted sweep leaves the current row untouched.
  always_comb begin
    ram_wr_ena  = 1'b0;
    ram_wr_addr = host_addr;
    ram_wr_data = host_wdata;
    if (!rst && state == CLEAR) begin
      ram_wr_ena  = 1'b1;
      ram_wr_addr = cnt;
      ram_wr_data = CLEAR_VAL;
    end else if (host_wr_grant) begin
      ram_wr_ena  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      disp_valid <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      resp_valid <= host_rd_grant;
      case (state)
        IDLE: if (clear_start) begin
          state      <= CLEAR;
          cnt        <= '0;
          clear_busy <= 1'b1;
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST) begin
            state      <= DONE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a read-before-write RAM model on the memory port,
// expected read data queued with a due cycle and matched when the DUT reports valid.
module tb_ram_arbiter;
  logic       clk = 0;
  logic       rst;
  always #5 clk = ~clk;

  // Default build, L=32
  logic       disp_req, host_valid, host_we, clear_start;
  logic [4:0] disp_addr, host_addr;
  logic [7:0] host_wdata;
  logic       disp_valid, host_ready, resp_valid, clear_busy, clear_done, ram_wr_ena;
  logic [7:0] disp_data, resp_data, ram_rd_data, ram_wr_data;
  logic [4:0] ram_rd_addr, ram_wr_addr;

  ram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .ram_wr_ena(ram_wr_ena),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
  );

  // Non-power-of-two build, L=20
  logic       b_host_valid, b_host_we, b_clear_start;
  logic [4:0] b_host_addr;
  logic [7:0] b_host_wdata;
  logic       b_disp_valid, b_host_ready, b_resp_valid, b_clear_busy, b_clear_done, b_ram_wr_ena;
  logic [7:0] b_disp_data, b_resp_data, b_ram_wr_data;
  logic [7:0] b_ram_rd_data = 8'h00;
  logic [4:0] b_ram_rd_addr, b_ram_wr_addr;
  logic       b_disp_req = 1'b0;
  logic [4:0] b_disp_addr = 5'd0;

  ram_arbiter #(.L(20)) u_dut20 (
    .clk(clk), .rst(rst),
    .disp_req(b_disp_req), .disp_addr(b_disp_addr), .disp_valid(b_disp_valid), .disp_data(b_disp_data),
    .host_valid(b_host_valid), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
    .host_ready(b_host_ready), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
    .clear_start(b_clear_start), .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .ram_rd_addr(b_ram_rd_addr), .ram_rd_data(b_ram_rd_data), .ram_wr_ena(b_ram_wr_ena),
    .ram_wr_addr(b_ram_wr_addr), .ram_wr_data(b_ram_wr_data)
  );

  // Attached block RAM: registered read, read-before-write
  logic [7:0] mem [32];
  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr_ena) mem[ram_wr_addr] <= ram_wr_data;
  end

  typedef struct { logic [7:0] d; int due; } exp_t;
  exp_t       disp_q[$], resp_q[$];
  logic [7:0] model [32];
  int         cyc_n = 0;
  int         checks = 0, errors = 0, done_cnt = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read data must appear exactly on the due cycle, and valid never without a pending entry
  always @(negedge clk) begin
    if (disp_valid && resp_valid) chk("both_valid", 1, 0);
    if (disp_q.size() > 0 && disp_q[0].due == cyc_n) begin
      chk("disp_valid", {31'd0, disp_valid}, 1);
      chk("disp_data", {24'd0, disp_data}, {24'd0, disp_q[0].d});
      disp_q.delete(0);
    end else if (disp_valid) chk("disp_spurious", 1, 0);
    if (resp_q.size() > 0 && resp_q[0].due == cyc_n) begin
      chk("resp_valid", {31'd0, resp_valid}, 1);
      chk("resp_data", {24'd0, resp_data}, {24'd0, resp_q[0].d});
      resp_q.delete(0);
    end else if (resp_valid) chk("resp_spurious", 1, 0);
    if (clear_done) done_cnt++;
  end

  task automatic push_disp(input logic [7:0] d);
    disp_q.push_back('{d: d, due: cyc_n + 1});
  endtask

  task automatic push_resp(input logic [7:0] d);
    resp_q.push_back('{d: d, due: cyc_n + 1});
  endtask

  // Advance to just after a rising edge and drop every u_dut input to idle
  task automatic cyc();
    @(posedge clk); #1;
    disp_req = 0; disp_addr = 0; host_valid = 0; host_we = 0;
    host_addr = 0; host_wdata = 0; clear_start = 0;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    cyc();
    host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
    #2;
    chk("wr_ready", {31'd0, host_ready}, 1);
    chk("wr_ena", {31'd0, ram_wr_ena}, 1);
    chk("wr_addr", {27'd0, ram_wr_addr}, {27'd0, a});
    chk("wr_data", {24'd0, ram_wr_data}, {24'd0, d});
    model[a] = d;
  endtask

  task automatic host_read(input logic [4:0] a);
    cyc();
    host_valid = 1; host_we = 0; host_addr = a;
    #2;
    chk("rd_ready", {31'd0, host_ready}, 1);
    chk("rd_addr", {27'd0, ram_rd_addr}, {27'd0, a});
    push_resp(model[a]);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 32; i++) host_write(5'(i), base + 8'(i));
  endtask

  initial begin
    rst = 1;
    b_host_valid = 0; b_host_we = 0; b_clear_start = 0; b_host_addr = 0; b_host_wdata = 0;
    cyc(); cyc(); cyc();
    #2;
    chk("rst_disp_valid", {31'd0, disp_valid}, 0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_clear_busy", {31'd0, clear_busy}, 0);
    chk("rst_clear_done", {31'd0, clear_done}, 0);
    chk("rst_wr_ena", {31'd0, ram_wr_ena}, 0);
    rst = 0;

    fill(8'h40);

    // Write 5 then read it back
    host_write(5'd5, 8'hA5);
    host_read(5'd5);

    // Display priority: host read waits out 4 cycles of display requests
    for (int i = 0; i < 4; i++) begin
      cyc();
      host_valid = 1; host_addr = 5'd9; disp_req = 1; disp_addr = 5'd3;
      #2;
      chk("contend_ready", {31'd0, host_ready}, 0);
      chk("contend_rd_addr", {27'd0, ram_rd_addr}, 27'd3);
      push_disp(model[3]);
    end
    host_read(5'd9);

    // Host write proceeds under a display read of the same row; display sees old data
    cyc();
    host_valid = 1; host_we = 1; host_addr = 5'd12; host_wdata = 8'h5A;
    disp_req = 1; disp_addr = 5'd12;
    #2;
    chk("wr_under_disp_ready", {31'd0, host_ready}, 1);
    chk("wr_under_disp_ena", {31'd0, ram_wr_ena}, 1);
    push_disp(model[12]);
    model[12] = 8'h5A;
    cyc();
    disp_req = 1; disp_addr = 5'd12;
    #2; push_disp(model[12]);

    // Clear sweep with concurrent display reads of row 7; clear wins over a host write
    host_write(5'd7, 8'h11);
    cyc();
    clear_start = 1; host_valid = 1; host_we = 1; host_addr = 5'd2; host_wdata = 8'h77;
    disp_req = 1; disp_addr = 5'd7;
    #2;
    chk("clr_vs_wr_ready", {31'd0, host_ready}, 0);
    chk("clr_vs_wr_ena", {31'd0, ram_wr_ena}, 0);
    push_disp(model[7]);
    for (int i = 0; i < 32; i++) begin
      cyc();
      clear_start = (i == 5);
      host_valid = 1; host_we = 1; host_addr = 5'd2; host_wdata = 8'h77;
      disp_req = 1; disp_addr = 5'd7;
      #2;
      chk("sweep_busy", {31'd0, clear_busy}, 1);
      chk("sweep_done", {31'd0, clear_done}, 0);
      chk("sweep_ready", {31'd0, host_ready}, 0);
      chk("sweep_ena", {31'd0, ram_wr_ena}, 1);
      chk("sweep_addr", {27'd0, ram_wr_addr}, 32'(i));
      chk("sweep_data", {24'd0, ram_wr_data}, 0);
      push_disp((i > 7) ? 8'h00 : model[7]);
    end
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    cyc();
    host_valid = 1; host_we = 1; host_addr = 5'd2; host_wdata = 8'h77;
    #2;
    chk("done_pulse", {31'd0, clear_done}, 1);
    chk("done_busy", {31'd0, clear_busy}, 0);
    chk("done_ready", {31'd0, host_ready}, 0);
    chk("done_ena", {31'd0, ram_wr_ena}, 0);
    host_write(5'd2, 8'h77);
    chk("post_done_low", {31'd0, clear_done}, 0);
    host_read(5'd0);
    host_read(5'd2);
    host_read(5'd7);
    host_read(5'd19);
    host_read(5'd31);
    cyc(); cyc();
    chk("done_count", 32'(done_cnt), 1);

    // Reset while the sweep counter is at 10
    fill(8'h80);
    cyc();
    clear_start = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #2; chk("abort_addr", {27'd0, ram_wr_addr}, 32'(i));
    end
    for (int i = 0; i < 10; i++) model[i] = 8'h00;
    cyc();
    rst = 1;
    #2;
    chk("abort_rst_ena", {31'd0, ram_wr_ena}, 0);
    cyc();
    rst = 0;
    #2;
    chk("abort_busy", {31'd0, clear_busy}, 0);
    chk("abort_done", {31'd0, clear_done}, 0);
    for (int i = 0; i < 32; i++) host_read(5'(i));
    cyc(); cyc(); cyc();
    chk("abort_done_count", 32'(done_cnt), 1);

    // L=20 build: clear beats a same-cycle host write and sweeps rows 0..19
    @(posedge clk); #1;
    b_clear_start = 1; b_host_valid = 1; b_host_we = 1; b_host_addr = 5'd3; b_host_wdata = 8'h99;
    #2;
    chk("l20_clr_ready", {31'd0, b_host_ready}, 0);
    chk("l20_clr_busy", {31'd0, b_clear_busy}, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      b_clear_start = 0;
      #2;
      chk("l20_busy", {31'd0, b_clear_busy}, 1);
      chk("l20_ena", {31'd0, b_ram_wr_ena}, 1);
      chk("l20_addr", {27'd0, b_ram_wr_addr}, 32'(i));
      chk("l20_ready", {31'd0, b_host_ready}, 0);
    end
    @(posedge clk); #3;
    chk("l20_done", {31'd0, b_clear_done}, 1);
    chk("l20_done_ena", {31'd0, b_ram_wr_ena}, 0);
    chk("l20_done_busy", {31'd0, b_clear_busy}, 0);
    @(posedge clk); #3;
    chk("l20_idle_ready", {31'd0, b_host_ready}, 1);
    chk("l20_idle_done", {31'd0, b_clear_done}, 0);
    chk("l20_idle_addr", {27'd0, b_ram_wr_addr}, 32'd3);
    @(posedge clk); #1;
    b_host_valid = 0;

    cyc(); cyc();
    chk("disp_q_drained", 32'(disp_q.size()), 0);
    chk("resp_q_drained", 32'(resp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
